// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, opcodes,
// ALU codes, immediate formats and datapath mux selects.
package rv32_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_FETCH     = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE    = 4'd1;
  localparam logic [STATE_W-1:0] S_MEM_ADR   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_READ  = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_WB    = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WRITE = 4'd5;
  localparam logic [STATE_W-1:0] S_EXEC_R    = 4'd6;
  localparam logic [STATE_W-1:0] S_EXEC_I    = 4'd7;
  localparam logic [STATE_W-1:0] S_JAL       = 4'd8;
  localparam logic [STATE_W-1:0] S_LUI       = 4'd9;
  localparam logic [STATE_W-1:0] S_ALU_WB    = 4'd10;
  localparam logic [STATE_W-1:0] S_BRANCH    = 4'd11;
  localparam logic [STATE_W-1:0] S_TRAP      = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam int unsigned ALU_CODE_W = 4;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Which rule the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    ALU_CLS_ADD    = 2'd0,
    ALU_CLS_R      = 2'd1,
    ALU_CLS_I      = 2'd2,
    ALU_CLS_BRANCH = 2'd3
  } alu_class_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle controller.
interface multicycle_control_if #(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CNT_W      = 32
);
  logic [6:0]            op_code;
  logic [2:0]            func3;
  logic [6:0]            func7;
  logic                  zero;
  logic                  lt;
  logic                  ltu;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  adr_src;
  logic                  ir_write;
  logic                  mem_write;
  logic                  reg_write;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            result_source;
  logic [2:0]            imm_type;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal_instr;
  logic [CNT_W-1:0]      instret;

  modport master (
    input  op_code, func3, func7, zero, lt, ltu, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a,
           alu_src_b, result_source, imm_type, alu_control, illegal_instr, instret
  );

  modport slave (
    output op_code, func3, func7, zero, lt, ltu, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write, alu_src_a,
           alu_src_b, result_source, imm_type, alu_control, illegal_instr, instret
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps (state class, func3, func7) to the ALU operation code.
module alu_decoder
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  alu_class_e            alu_class,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [ALU_CODE_W-1:0] code;
  logic                  alt;
  logic                  unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  always_comb begin
    code = ALU_ADD;
    alt  = func7[5];
    case (alu_class)
      ALU_CLS_ADD: code = ALU_ADD;
      ALU_CLS_R, ALU_CLS_I: begin
        case (func3)
          3'b000:  code = (alt && (alu_class == ALU_CLS_R)) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = alt ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
      // Unsigned branch compares need SLTU; everything else compares via SUB flags.
      ALU_CLS_BRANCH: code = (func3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32I datapath with a shared ALU, a unified
// memory port with ready handshake, and a retired-instruction counter.
module multicycle_control
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W    = 4,
  parameter int unsigned CNT_W         = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_next;
  logic [STATE_W-1:0]    state_dec;
  logic [CNT_W-1:0]      instret;
  logic                  retire;
  logic                  ready;
  logic                  taken;
  alu_class_e            alu_class;
  logic [ALU_CTRL_W-1:0] alu_control;

  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_source;
  logic [2:0] imm_type;
  logic       illegal_instr;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state;
    retire        = 1'b0;
    state_dec     = rst ? S_FETCH : state;
    taken         = 1'b0;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_source = RES_ALU_OUT;
    imm_type      = IMM_I;
    alu_class     = ALU_CLS_ADD;
    illegal_instr = 1'b0;

    case (bus.func3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.lt;
      3'b101:  taken = !bus.lt;
      3'b110:  taken = bus.ltu;
      3'b111:  taken = !bus.ltu;
      default: taken = 1'b0;
    endcase

    // Next state and retirement.
    case (state)
      S_FETCH: if (ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op_code)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_JAL:            state_next = S_JAL;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADR:  state_next = bus.op_code[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: if (ready) state_next = S_MEM_WB;
      S_MEM_WRITE: begin
        if (ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI: state_next = S_ALU_WB;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase

    // Moore output decode; reset presents FETCH values.
    case (state_dec)
      S_FETCH: begin
        alu_src_b     = SRC_B_FOUR;
        result_source = RES_ALU;
        ir_write      = ready;
        pc_write      = ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_type  = IMM_B;
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_type  = bus.op_code[5] ? IMM_S : IMM_I;
      end
      S_MEM_READ: adr_src = 1'b1;
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEM_WB: begin
        result_source = RES_MEM;
        reg_write     = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_class = ALU_CLS_R;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_class = ALU_CLS_I;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        imm_type  = IMM_U;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_class = ALU_CLS_BRANCH;
        pc_write  = taken;
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: illegal_instr = 1'b0;
    endcase
  end

  alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_class   (alu_class),
    .func3       (bus.func3),
    .func7       (bus.func7),
    .alu_control (alu_control)
  );

  assign bus.pc_write      = pc_write;
  assign bus.adr_src       = adr_src;
  assign bus.ir_write      = ir_write;
  assign bus.mem_write     = mem_write;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.result_source = result_source;
  assign bus.imm_type      = imm_type;
  assign bus.alu_control   = alu_control;
  assign bus.illegal_instr = illegal_instr;
  assign bus.instret       = instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: an instruction-level phase model predicts every output each cycle.
module tb_multicycle_control;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_JAL = 8, P_LUI = 9,
                 P_ALUWB = 10, P_BRANCH = 11, P_TRAP = 12;

  typedef struct packed {
    logic        pc_write;
    logic        adr_src;
    logic        ir_write;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  src_a;
    logic [1:0]  src_b;
    logic [1:0]  res;
    logic [2:0]  imm;
    logic [3:0]  alu;
    logic        ill;
    logic [31:0] instret;
    logic [3:0]  instret4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] fn3 = 3'd0;
  logic [6:0] fn7 = 7'd0;
  logic zero_v = 1'b0, lt_v = 1'b0, ltu_v = 1'b0, rdy_v = 1'b1;

  int   n_checks = 0;
  int   n_fail = 0;
  int   retired = 0;
  int   cur_ph = 0;
  bit   exp_valid = 1'b0;
  exp_t exp_v;
  exp_t act_v;
  logic br_pc;
  logic [3:0] exec_alu;
  int   mw_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.ALU_CTRL_W(4), .CNT_W(32)) bus ();
  multicycle_control_if #(.ALU_CTRL_W(4), .CNT_W(4))  bus4 ();

  assign bus.op_code   = op;   assign bus4.op_code   = op;
  assign bus.func3     = fn3;  assign bus4.func3     = fn3;
  assign bus.func7     = fn7;  assign bus4.func7     = fn7;
  assign bus.zero      = zero_v; assign bus4.zero    = zero_v;
  assign bus.lt        = lt_v; assign bus4.lt        = lt_v;
  assign bus.ltu       = ltu_v; assign bus4.ltu      = ltu_v;
  assign bus.mem_ready = rdy_v; assign bus4.mem_ready = rdy_v;

  multicycle_control #(.ALU_CTRL_W(4), .CNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.master));
  multicycle_control #(.ALU_CTRL_W(4), .CNT_W(4), .MEM_HANDSHAKE(1'b1)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.master));

  // ALU code for each func3 of a register op, with func7[5] clear.
  function automatic logic [3:0] r_op(input logic [2:0] f3, input logic alt, input bit imm);
    int tab [8] = '{0, 6, 5, 9, 4, 7, 3, 2};
    if (f3 == 3'd0 && alt && !imm) return 4'd1;
    if (f3 == 3'd5 && alt) return 4'd8;
    return 4'(tab[f3]);
  endfunction

  function automatic exp_t model(input int ph, input logic rdy);
    exp_t e;
    e = '0;
    case (ph)
      P_FETCH:    begin e.src_b = 2; e.res = 2; e.ir_write = rdy; e.pc_write = rdy; end
      P_DECODE:   begin e.src_a = 1; e.src_b = 1; e.imm = 2; end
      P_MEMADR:   begin e.src_a = 2; e.src_b = 1; e.imm = (op == 7'b0100011) ? 3'd1 : 3'd0; end
      P_MEMREAD:  e.adr_src = 1;
      P_MEMWRITE: begin e.adr_src = 1; e.mem_write = 1; end
      P_MEMWB:    begin e.res = 1; e.reg_write = 1; end
      P_EXECR:    begin e.src_a = 2; e.alu = r_op(fn3, fn7[5], 1'b0); end
      P_EXECI:    begin e.src_a = 2; e.src_b = 1; e.alu = r_op(fn3, fn7[5], 1'b1); end
      P_JAL:      begin e.src_a = 1; e.src_b = 2; e.pc_write = 1; end
      P_LUI:      begin e.src_a = 3; e.src_b = 1; e.imm = 4; end
      P_ALUWB:    e.reg_write = 1;
      P_BRANCH: begin
        e.src_a = 2;
        e.alu = (fn3 >= 3'd6) ? 4'd9 : 4'd1;
        case (fn3)
          3'd0: e.pc_write = zero_v;
          3'd1: e.pc_write = !zero_v;
          3'd4: e.pc_write = lt_v;
          3'd5: e.pc_write = !lt_v;
          3'd6: e.pc_write = ltu_v;
          3'd7: e.pc_write = !ltu_v;
          default: e.pc_write = 1'b0;
        endcase
      end
      default: e.ill = 1;
    endcase
    e.instret  = 32'(retired);
    e.instret4 = 4'(retired);
    return e;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (exp_valid) begin
      act_v = {bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write, bus.reg_write,
               bus.alu_src_a, bus.alu_src_b, bus.result_source, bus.imm_type,
               bus.alu_control, bus.illegal_instr, bus.instret, bus4.instret};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle phase=%0d t=%0t: got %h expected %h", cur_ph, $time, act_v, exp_v);
      end
      if (cur_ph == P_BRANCH) br_pc = bus.pc_write;
      if (cur_ph == P_EXECR || cur_ph == P_EXECI) exec_alu = bus.alu_control;
      if (bus.mem_write) mw_cnt++;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step(input int ph, input logic rdy);
    rdy_v = rdy;
    cur_ph = ph;
    exp_v = model(ph, rdy);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(P_FETCH, 1'b1);
    rst = 1'b0;
    retired = 0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic l, input logic lu,
                           input int fw, input int mw);
    op = o; fn3 = f3; fn7 = f7; zero_v = z; lt_v = l; ltu_v = lu;
    for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0);
    step(P_FETCH, 1'b1);
    step(P_DECODE, 1'b0);
    case (o)
      7'b0000011: begin
        step(P_MEMADR, 1'b0);
        for (int i = 0; i < mw; i++) step(P_MEMREAD, 1'b0);
        step(P_MEMREAD, 1'b1);
        step(P_MEMWB, 1'b0);
        retired++;
      end
      7'b0100011: begin
        step(P_MEMADR, 1'b0);
        for (int i = 0; i < mw; i++) step(P_MEMWRITE, 1'b0);
        step(P_MEMWRITE, 1'b1);
        retired++;
      end
      7'b0110011: begin step(P_EXECR, 1'b0); step(P_ALUWB, 1'b0); retired++; end
      7'b0010011: begin step(P_EXECI, 1'b0); step(P_ALUWB, 1'b0); retired++; end
      7'b1101111: begin step(P_JAL, 1'b0);   step(P_ALUWB, 1'b0); retired++; end
      7'b0110111: begin step(P_LUI, 1'b0);   step(P_ALUWB, 1'b0); retired++; end
      7'b1100011: begin step(P_BRANCH, 1'b0); retired++; end
      default:    step(P_TRAP, 1'b1);
    endcase
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    lit("reset_instret", bus.instret, 32'd0);

    run_instr(7'b0000011, 3'b010, 7'd0, 0, 0, 0, 0, 0);          // lw
    lit("lw_instret", bus.instret, 32'd1);

    mw_cnt = 0;
    run_instr(7'b0100011, 3'b010, 7'd0, 0, 0, 0, 1, 3);          // sw, waits
    lit("sw_mem_write_cycles", 32'(mw_cnt), 32'd4);

    run_instr(7'b1100011, 3'b001, 7'd0, 0, 0, 0, 0, 0);          // bne taken
    lit("bne_taken", {31'd0, br_pc}, 32'd1);
    run_instr(7'b1100011, 3'b001, 7'd0, 1, 0, 0, 0, 0);          // bne not taken
    lit("bne_not_taken", {31'd0, br_pc}, 32'd0);
    run_instr(7'b1100011, 3'b000, 7'd0, 1, 0, 0, 0, 0);          // beq
    run_instr(7'b1100011, 3'b100, 7'd0, 0, 1, 0, 0, 0);          // blt
    run_instr(7'b1100011, 3'b101, 7'd0, 0, 1, 0, 0, 0);          // bge
    run_instr(7'b1100011, 3'b110, 7'd0, 0, 0, 1, 0, 0);          // bltu
    run_instr(7'b1100011, 3'b111, 7'd0, 0, 0, 0, 0, 0);          // bgeu
    run_instr(7'b1100011, 3'b010, 7'd0, 1, 1, 1, 0, 0);          // reserved func3

    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0, 0);    // sub
    lit("sub_alu", 32'(exec_alu), 32'd1);
    run_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 0, 0);    // srai
    lit("srai_alu", 32'(exec_alu), 32'd8);
    run_instr(7'b0010011, 3'b000, 7'b0100000, 0, 0, 0, 0, 0);    // addi with func7[5] set
    lit("addi_alu", 32'(exec_alu), 32'd0);
    for (int f = 0; f < 8; f++) begin
      run_instr(7'b0110011, 3'(f), 7'd0, 0, 0, 0, 0, 0);
      run_instr(7'b0010011, 3'(f), 7'd0, 0, 0, 0, 0, 0);
    end
    run_instr(7'b0110011, 3'b101, 7'b0100000, 0, 0, 0, 0, 0);    // sra
    run_instr(7'b1101111, 3'b000, 7'd0, 0, 0, 0, 0, 0);          // jal
    run_instr(7'b0110111, 3'b000, 7'd0, 0, 0, 0, 0, 0);          // lui
    run_instr(7'b0000011, 3'b010, 7'd0, 0, 0, 0, 2, 2);          // lw with waits
    run_instr(7'b0100011, 3'b010, 7'd0, 0, 0, 0, 0, 0);          // sw, no wait

    run_instr(7'b0000000, 3'b000, 7'd0, 0, 0, 0, 0, 0);          // illegal
    step(P_TRAP, 1'b1);
    step(P_TRAP, 1'b0);
    lit("trap_illegal", {31'd0, bus.illegal_instr}, 32'd1);
    do_reset();
    lit("trap_reset_instret", bus.instret, 32'd0);

    for (int i = 0; i < 16; i++) run_instr(7'b0110011, 3'b000, 7'd0, 0, 0, 0, 0, 0);
    lit("wrap4_instret", 32'(bus4.instret), 32'd0);
    lit("add16_instret", bus.instret, 32'd16);

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle RV32I control unit. It replaces the single-cycle main/ALU decoder with a Moore state machine that shares one ALU and one unified memory port across fetch, decode, execute, memory and writeback cycles. It adds a memory ready handshake, a wider ALU control code, more branch conditions and a retired-instruction counter. It sits between the instruction register / ALU flags and the multicycle datapath muxes and enables.

## Interface
- `ALU_CTRL_W`, default 4: ALU control width. Minimum 4.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `MEM_HANDSHAKE`, default 1: when 1, memory states wait for `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `op_code` in 7: opcode from the instruction register.
- `func3` in 3: instruction register bits [14:12].
- `func7` in 7: instruction register bits [31:25].
- `zero`, `lt`, `ltu` in 1 each: ALU flags for equal, signed-less-than and unsigned-less-than.
- `mem_ready` in 1: memory has completed the current access.
- `pc_write` out 1: load the PC.
- `adr_src` out 1: memory address select. 0 selects the PC, 1 selects the ALU-out register.
- `ir_write` out 1: load the instruction register and the old-PC register.
- `mem_write` out 1: store strobe.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: ALU A select. 00 PC, 01 old PC, 10 rs1, 11 zero.
- `alu_src_b` out 2: ALU B select. 00 rs2, 01 immediate, 10 constant 4.
- `result_source` out 2: result select. 00 ALU-out register, 01 memory data, 10 ALU result.
- `imm_type` out 3: immediate format. 000 I, 001 S, 010 B, 011 J, 100 U.
- `alu_control` out ALU_CTRL_W: ALU operation code.
- `illegal_instr` out 1: high while in TRAP.
- `instret` out CNT_W: count of retired instructions.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, JAL, LUI, ALU_WB, BRANCH, TRAP.
- State transitions:
  - FETCH goes to DECODE when `mem_ready`. Otherwise it holds.
  - DECODE decodes `op_code`:
    - 0000011 and 0100011 go to MEM_ADR.
    - 0110011 goes to EXEC_R.
    - 0010011 goes to EXEC_I.
    - 1101111 goes to JAL.
    - 1100011 goes to BRANCH.
    - 0110111 goes to LUI.
    - Any other opcode goes to TRAP.
  - MEM_ADR goes to MEM_READ for loads and MEM_WRITE for stores.
  - MEM_READ goes to MEM_WB when `mem_ready`.
  - MEM_WRITE goes to FETCH when `mem_ready`.
  - MEM_WB, ALU_WB and BRANCH go to FETCH.
  - EXEC_R, EXEC_I, JAL and LUI go to ALU_WB.
  - TRAP holds until `rst`.
- Outputs are Moore outputs, decoded from the state. Every output is 0 unless listed below.
  - FETCH:
    - `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ALU op ADD, `result_source`=10.
    - `ir_write` and `pc_write` are both equal to the effective `mem_ready`.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, `imm_type`=B, ADD. This precomputes the branch target.
  - MEM_ADR:
    - `alu_src_a`=10, `alu_src_b`=01, ADD.
    - `imm_type` is I for a load and S for a store.
  - MEM_READ: `adr_src`=1.
  - MEM_WRITE: `adr_src`=1, `mem_write`=1.
  - MEM_WB: `result_source`=01, `reg_write`=1.
  - EXEC_R: `alu_src_a`=10, `alu_src_b`=00, ALU op from the R decode below.
  - EXEC_I: `alu_src_a`=10, `alu_src_b`=01, `imm_type`=I, ALU op from the I decode below.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, ADD, `result_source`=00, `pc_write`=1.
  - LUI: `alu_src_a`=11, `alu_src_b`=01, `imm_type`=U, ADD.
  - ALU_WB: `result_source`=00, `reg_write`=1.
  - BRANCH:
    - `alu_src_a`=10, `alu_src_b`=00, `result_source`=00.
    - ALU op is SUB for BEQ/BNE and for BLT/BGE, and SLTU for BLTU/BGEU.
    - `pc_write` equals the "taken" condition below.
  - TRAP: `illegal_instr`=1.
- ALU codes, zero-extended to `ALU_CTRL_W`: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7, SRA 8, SLTU 9.
- R decode by `func3`:
  - 000 is SUB when `func7[5]` is set, otherwise ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101 is SRA when `func7[5]` is set, otherwise SRL.
- I decode is the same as R decode, except that 000 is always ADD.
- Branch "taken" by `func3`:
  - 000 taken when `zero`; 001 taken when `!zero`.
  - 100 taken when `lt`; 101 taken when `!lt`.
  - 110 taken when `ltu`; 111 taken when `!ltu`.
  - Any other `func3` is not taken.
- Counter:
  - `instret` increments by 1 on every transition into FETCH from MEM_WB, ALU_WB, BRANCH or MEM_WRITE.
  - It wraps modulo 2^CNT_W.

## Timing
- Reset:
  - `rst` sampled high forces the state to FETCH and `instret` to 0 on that edge, from any state, including mid-wait and TRAP.
  - During reset the outputs are FETCH decode values, with `ir_write`/`pc_write` following `mem_ready`.
- Cycles per instruction with `mem_ready` held high:
  - Load: 5.
  - Store: 4.
  - R-type, I-type, JAL, LUI: 4.
  - Branch: 3.
- Each low cycle of `mem_ready` in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- No strobe repeats while the block waits for `mem_ready`.
  - `mem_write` stays high for the whole MEM_WRITE wait.
  - `ir_write` stays low in FETCH until `mem_ready`.
- If `mem_ready` is already high on entry to a wait state, no wait cycle is added.

## Structure
- `rv32_ctrl_pkg` holds:
  - the state enum;
  - the opcode, ALU-code, imm-type and mux-select localparams.
- One sub-module, `alu_decoder`: a combinational mapping from (state class, `func3`, `func7`) to `alu_control`, parametrised by `ALU_CTRL_W`.
- The FSM, the output decode and the counter live in `multicycle_control`.

## Test plan
- Reset, then `lw` (op 0000011) with `mem_ready`=1:
  - states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, FETCH;
  - `reg_write`=1 only in MEM_WB;
  - `instret`=1.
- `sw` with `mem_ready` low for 3 cycles in MEM_WRITE: `mem_write` stays high for 4 cycles, then FETCH.
- `bne` (func3 001) with `zero`=0: `pc_write`=1 in BRANCH; repeat with `zero`=1: `pc_write`=0.
- `sub` (func3 000, func7 0100000): `alu_control`=1 in EXEC_R; `srai` (0010011/101, func7[5]=1): `alu_control`=8.
- Opcode 0000000: TRAP, `illegal_instr`=1 held; `rst`=1 for one cycle returns to FETCH with `instret`=0.
- With `CNT_W`=4, run 16 `add` instructions: `instret` wraps to 0.
